// File: rtl/bch_t12_normal_parity_engine.sv
// BCH (t=12, DVB-S2 normal frame) parity engine: folds 24-bit message words into a 192-bit
// remainder using a 24-row contribution ROM. Optional build macro: BCH_ZERO_SKIP_EN (read only rows with feedback set).
module bch_t12_normal_parity_engine #(
    parameter int ROM_LAT = 1
) (
    input  logic         clk_1x,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [23:0]  s_data,
    input  logic         s_last,
    input  logic [1:0]   s_nbytes,
    output logic         rom_rd_en,
    output logic [4:0]   rom_rdaddr,
    input  logic [191:0] rom_rd_q,
    output logic         m_valid,
    output logic [23:0]  m_data,
    output logic         m_last,
    input  logic         m_ready,
    output logic         busy,
    output logic [1:0]   dbg_state
);

    // Both streams move one word on a rising edge where valid and ready are both high;
    // valid never waits on ready, and m_data/m_last stay stable until the word is taken.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, OUT = 2'd3} state_t;

    state_t               state_q, state_d;
    logic [191:0]         r_q, r_d;
    logic [23:0]          f_q, f_d, f_new;
    logic [4:0]           k_q, k_d, wm;
    logic                 last_q, last_d;
    logic [2:0]           oc_q, oc_d;
    logic                 rd_en_q, rd_en_d;
    logic [ROM_LAT-1:0]   tag_v, tag_f;
    logic                 tag_in_v, tag_in_f;
    logic [7:0]           out_hi;
`ifdef BCH_ZERO_SKIP_EN
    function automatic logic [4:0] lowest_set(input logic [23:0] v);
        lowest_set = '0;
        for (int i = 23; i >= 0; i--) begin
            if (v[i]) lowest_set = 5'(i);
        end
    endfunction
`else
    logic [4:0]           m_q, m_d;
`endif

    // Shift amount and feedback bits for the word on the input port.
    always_comb begin
        wm = 5'd24;
        if (s_last) begin
            case (s_nbytes)
                2'd1:    wm = 5'd8;
                2'd2:    wm = 5'd16;
                default: wm = 5'd24;
            endcase
        end
        case (wm)
            5'd8:    f_new = {16'd0, r_q[191:184] ^ s_data[23:16]};
            5'd16:   f_new = {8'd0, r_q[191:176] ^ s_data[23:8]};
            default: f_new = r_q[191:168] ^ s_data;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        r_d      = r_q;
        f_d      = f_q;
        k_d      = k_q;
        last_d   = last_q;
        oc_d     = oc_q;
        rd_en_d  = 1'b0;
        tag_in_v = 1'b0;
        tag_in_f = 1'b0;
`ifndef BCH_ZERO_SKIP_EN
        m_d      = m_q;
`endif
        // The tag pipe is empty outside READ/DRAIN, so this only fires there.
        if (tag_v[ROM_LAT-1] && tag_f[ROM_LAT-1]) r_d = r_q ^ rom_rd_q;
        case (state_q)
            IDLE: begin
                if (s_valid) begin
                    r_d    = r_q << wm;
                    last_d = s_last;
`ifdef BCH_ZERO_SKIP_EN
                    if (f_new == '0) begin
                        state_d = s_last ? OUT : IDLE;
                        k_d     = '0;
                    end else begin
                        state_d = READ;
                        rd_en_d = 1'b1;
                        k_d     = lowest_set(f_new);
                        f_d     = f_new & ~(24'd1 << lowest_set(f_new));
                    end
`else
                    m_d     = wm;
                    f_d     = f_new;
                    k_d     = '0;
                    state_d = READ;
                    rd_en_d = 1'b1;
`endif
                end
            end
            READ: begin
                tag_in_v = 1'b1;
`ifdef BCH_ZERO_SKIP_EN
                tag_in_f = 1'b1;
                if (f_q == '0) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    rd_en_d = 1'b1;
                    k_d     = lowest_set(f_q);
                    f_d     = f_q & ~(24'd1 << lowest_set(f_q));
                end
`else
                tag_in_f = f_q[k_q];
                if (k_q == m_q - 5'd1) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end else begin
                    rd_en_d = 1'b1;
                    k_d     = k_q + 5'd1;
                end
`endif
            end
            DRAIN: begin
                if (k_q == 5'(ROM_LAT - 1)) begin
                    state_d = last_q ? OUT : IDLE;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            OUT: begin
                if (m_ready) begin
                    if (oc_q == 3'd7) begin
                        oc_d    = '0;
                        r_d     = '0;
                        state_d = IDLE;
                    end else begin
                        oc_d = oc_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_1x or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            f_q     <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            oc_q    <= '0;
            rd_en_q <= 1'b0;
            tag_v   <= '0;
            tag_f   <= '0;
`ifndef BCH_ZERO_SKIP_EN
            m_q     <= '0;
`endif
        end else begin
            state_q  <= state_d;
            r_q      <= r_d;
            f_q      <= f_d;
            k_q      <= k_d;
            last_q   <= last_d;
            oc_q     <= oc_d;
            rd_en_q  <= rd_en_d;
            tag_v[0] <= tag_in_v;
            tag_f[0] <= tag_in_f;
            for (int i = 1; i < ROM_LAT; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_f[i] <= tag_f[i-1];
            end
`ifndef BCH_ZERO_SKIP_EN
            m_q      <= m_d;
`endif
        end
    end

    assign out_hi     = 8'd191 - 8'(oc_q) * 8'd24;
    assign s_ready    = rst_n && (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign m_valid    = (state_q == OUT);
    assign m_last     = m_valid && (oc_q == 3'd7);
    assign m_data     = m_valid ? r_q[out_hi -: 24] : 24'd0;
    assign rom_rd_en  = rd_en_q;
    assign rom_rdaddr = rd_en_q ? k_q : 5'd0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_bch_t12_normal_parity_engine.sv
// Bench for bch_t12_normal_parity_engine: ROM built from g(x), bit-serial LFSR reference,
// scoreboard queue of expected parity blocks, immediate-assertion checks.
module tb_bch_t12_normal_parity_engine;

    localparam int ROM_LAT = 1;
    localparam int BOUND   = 2000;

    logic         clk_1x, rst_n;
    logic         s_valid, s_ready, s_last;
    logic [23:0]  s_data;
    logic [1:0]   s_nbytes;
    logic         rom_rd_en;
    logic [4:0]   rom_rdaddr;
    logic [191:0] rom_rd_q;
    logic         m_valid, m_last, m_ready, busy;
    logic [23:0]  m_data;
    logic [1:0]   dbg_state;

    bch_t12_normal_parity_engine #(.ROM_LAT(ROM_LAT)) dut (
        .clk_1x(clk_1x), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_nbytes(s_nbytes),
        .rom_rd_en(rom_rd_en), .rom_rdaddr(rom_rdaddr), .rom_rd_q(rom_rd_q),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk_1x = 1'b0;
    always #5 clk_1x = ~clk_1x;

    int cyc = 0;
    always @(posedge clk_1x) cyc <= cyc + 1;

    // ROM model: rows x^(192+j) mod g(x); junk on cycles without a read strobe
    logic [16:0]  gmin [12] = '{17'h1002D, 17'h10173, 17'h10FBD, 17'h15A55, 17'h11F2F, 17'h1F7B5,
                                17'h1AF65, 17'h17367, 17'h10EA1, 17'h175A7, 17'h13A2D, 17'h11AE3};
    logic [191:0] glow;
    logic [191:0] rom [24];
    logic [191:0] rq_pipe [ROM_LAT];

    always @(posedge clk_1x) begin
        rq_pipe[0] <= rom_rd_en ? rom[rom_rdaddr] : {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < ROM_LAT; i++) rq_pipe[i] <= rq_pipe[i-1];
    end
    assign rom_rd_q = rq_pipe[ROM_LAT-1];

    int         rd_total = 0;
    logic [4:0] addr_log[$];
    always @(negedge clk_1x) begin
        if (rom_rd_en === 1'b1) begin
            rd_total <= rd_total + 1;
            addr_log.push_back(rom_rdaddr);
        end
    end

    // scoreboard
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [191:0] exp_q[$];
    bit           msg_bits[$];
    int           acc_cyc;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [191:0] ref_parity();
        logic [191:0] r;
        logic         fb;
        r = '0;
        foreach (msg_bits[i]) begin
            fb = r[191] ^ msg_bits[i];
            r  = r << 1;
            if (fb) r ^= glow;
        end
        return r;
    endfunction

    task automatic expect_ref();
        exp_q.push_back(ref_parity());
        msg_bits.delete();
    endtask

    task automatic expect_val(input logic [191:0] v);
        exp_q.push_back(v);
        msg_bits.delete();
    endtask

    // drivers
    task automatic send_word(input logic [23:0] d, input logic last, input logic [1:0] nb);
        int t;
        int nbits;
        t = 0;
        while (s_ready !== 1'b1 && t < BOUND) begin
            @(negedge clk_1x);
            t++;
        end
        if (t >= BOUND) check("ready_timeout", 0, 1);
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        s_nbytes = nb;
        @(posedge clk_1x);
        #1;
        acc_cyc  = cyc - 1;
        s_valid  = 1'b0;
        s_data   = 24'($urandom);
        s_last   = 1'b0;
        s_nbytes = 2'($urandom);
        nbits    = last ? ((nb == 2'd0) ? 24 : 8 * int'(nb)) : 24;
        for (int i = 0; i < nbits; i++) msg_bits.push_back(d[23-i]);
    endtask

    task automatic send_random_frame(input int nwords);
        for (int w = 0; w < nwords; w++)
            send_word(24'($urandom), (w == nwords - 1), 2'($urandom));
    endtask

    task automatic wait_ready_lat(input int exp_lat);
        int t;
        t = 0;
        while (s_ready !== 1'b1 && t < BOUND) begin
            @(negedge clk_1x);
            t++;
        end
        check("ready_latency", cyc - acc_cyc, exp_lat);
    endtask

    task automatic collect_frame(input string tag, input bit stall, input int exp_lat);
        logic [191:0] p;
        logic [23:0]  held;
        bit           was_stalled, first;
        int           beats, t;
        p = '0; held = '0; was_stalled = 0; first = 1; beats = 0; t = 0;
        while (beats < 8 && t < BOUND) begin
            @(negedge clk_1x);
            t++;
            m_ready = stall ? ((t % 3) == 1) : 1'b1;
            if (stall) begin
                s_valid = 1'b1;
                s_data  = 24'($urandom);
            end
            if (was_stalled) check("valid_hold", m_valid, 1);
            if (m_valid === 1'b1) begin
                if (first && exp_lat > 0) check("first_beat_latency", cyc - acc_cyc, exp_lat);
                first = 0;
                if (was_stalled) check("data_hold", m_data, held);
                check("s_ready_in_out", s_ready, 0);
                check("m_last", m_last, (beats == 7));
                if (m_ready) begin
                    p[191 - 24 * beats -: 24] = m_data;
                    beats++;
                    was_stalled = 0;
                end else begin
                    held = m_data;
                    was_stalled = 1;
                end
            end
        end
        if (beats < 8) check("beats_timeout", beats, 8);
        @(posedge clk_1x);
        #1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        check("idle_after_last", {busy, s_ready, m_valid}, 3'b010);
        check(tag, p, exp_q.pop_front());
    endtask

    // directed sequence
    initial begin
        logic [192:0] gp, acc;
        logic [191:0] r;
        int           base_rd, base_addr;

        gp = 193'd1;
        for (int i = 0; i < 12; i++) begin
            acc = '0;
            for (int b = 0; b < 17; b++) if (gmin[i][b]) acc ^= gp << b;
            gp = acc;
        end
        glow = gp[191:0];
        r = glow;
        for (int j = 0; j < 24; j++) begin
            rom[j] = r;
            r = (r << 1) ^ (r[191] ? glow : 192'd0);
        end

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_nbytes = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk_1x);
        check("reset_s_ready", s_ready, 0);
        check("reset_outputs", {rom_rd_en, rom_rdaddr, m_valid, m_data, m_last, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk_1x);
        check("idle_after_reset", {s_ready, busy}, 2'b10);

        // single MSB bit, full word: parity is row 23
        base_rd = rd_total;
        send_word(24'h800000, 1'b1, 2'd3);
        expect_val(rom[23]);
`ifdef BCH_ZERO_SKIP_EN
        collect_frame("row23_parity", 0, 1 + 1 + ROM_LAT);
        check("row23_reads", rd_total - base_rd, 1);
`else
        collect_frame("row23_parity", 0, 1 + 24 + ROM_LAT);
        check("row23_reads", rd_total - base_rd, 24);
`endif

        // single byte: parity is row 7
        base_rd = rd_total;
        base_addr = addr_log.size();
        send_word(24'h800000 | 24'($urandom_range(0, 16'hFFFF)), 1'b1, 2'd1);
        expect_val(rom[7]);
        collect_frame("row7_parity", 0, 0);
`ifdef BCH_ZERO_SKIP_EN
        check("row7_reads", rd_total - base_rd, 1);
        check("row7_addr", addr_log[base_addr], 7);
`else
        check("row7_reads", rd_total - base_rd, 8);
        for (int i = 0; i < 8; i++) check("row7_addr", addr_log[base_addr + i], i);
`endif

        // two low-bit words, with ready latency on the first
        send_word(24'h000001, 1'b0, 2'($urandom));
`ifdef BCH_ZERO_SKIP_EN
        wait_ready_lat(1 + 1 + ROM_LAT);
`else
        wait_ready_lat(1 + 24 + ROM_LAT);
`endif
        send_word(24'h000001, 1'b1, 2'd3);
        expect_ref();
        collect_frame("two_word_parity", 0, 0);

        // stalled output, s_valid held high during OUT
        send_random_frame(3);
        expect_ref();
        collect_frame("stall_parity", 1, 0);

        // short random frames with random partial last words
        for (int n = 0; n < 4; n++) begin
            send_random_frame($urandom_range(1, 5));
            expect_ref();
            collect_frame("short_random_parity", n[0], 0);
        end

        // full-length all-zero frame
        base_rd = rd_total;
        for (int w = 0; w < 1342; w++) send_word(24'd0, (w == 1341), 2'd3);
        expect_val(192'd0);
        collect_frame("zero_frame_parity", 0, 0);
`ifdef BCH_ZERO_SKIP_EN
        check("zero_frame_reads", rd_total - base_rd, 0);
`else
        check("zero_frame_reads", rd_total - base_rd, 24 * 1342);
`endif

        // full-length random frame
        send_random_frame(1342);
        expect_ref();
        collect_frame("long_random_parity", 0, 0);

        // reset during word 5, then a clean frame
        for (int w = 0; w < 5; w++) send_word(24'($urandom) | 24'h800000, 1'b0, 2'd3);
        @(negedge clk_1x);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_s_ready", s_ready, 0);
        check("abort_outputs", {rom_rd_en, rom_rdaddr, m_valid, m_data, m_last, busy}, 0);
        @(posedge clk_1x);
        @(negedge clk_1x);
        rst_n = 1'b1;
        msg_bits.delete();
        @(negedge clk_1x);
        send_word(24'h800000, 1'b1, 2'd3);
        expect_val(rom[23]);
        collect_frame("post_abort_parity", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_200_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
